// File: rtl/prefix_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix subtractor.
// gp_t carries one (generate, propagate) pair; combine() is the prefix operator.
package prefix_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // First-stage prefix depth for the default 8-bit operand width.
   localparam int PREFIX_S1_LEVELS = 2;

   function automatic int prefix_levels(input int width);
      return $clog2(width);
   endfunction

   // Stage 1 takes ceil(levels/2) prefix levels, stage 2 the remainder.
   function automatic int prefix_s1_levels(input int width);
      return ($clog2(width) + 1) / 2;
   endfunction

   // hi covers the more significant span, lo the adjacent lower span.
   function automatic gp_t combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Single (G,P) combine cell of the radix-2 prefix tree.
module prefix_gp_cell
   import prefix_pkg::*;
(
   input  gp_t i_hi,
   input  gp_t i_lo,
   output gp_t o_gp
);

   assign o_gp = combine(i_hi, i_lo);

endmodule

// File: rtl/prefixsub8_pipe.sv
// Two-stage pipelined a - b using a Kogge-Stone (G,P) tree with carry-in 1.
// Optional signed-overflow output enabled by defining PREFIXSUB_OVF_EN.
module prefixsub8_pipe
   import prefix_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef PREFIXSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int LEVELS = prefix_levels(WIDTH);
   localparam int S1_LVL = prefix_s1_levels(WIDTH);

   logic             r_s1_valid;
   logic             r_s2_valid;
   logic             w_s1_adv;
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] w_p0;
   logic [WIDTH-1:0] w_g0_cin;
   logic [WIDTH-1:0] r_s1_g;
   logic [WIDTH-1:0] r_s1_pp;
   logic [WIDTH-1:0] r_s1_p;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             w_unused_p;

   // Handshake: a stage advances when the one after it is empty or draining.
   // in_ready depends on out_ready and state only, never on in_valid.
   assign w_s1_adv = ~r_s2_valid | out_ready;
   assign in_ready = ~rst & (~r_s1_valid | w_s1_adv);

   // a + ~b + 1: the constant carry-in is folded into bit 0's generate.
   assign w_g0     = a & ~b;
   assign w_p0     = a ^ ~b;
   assign w_g0_cin = {w_g0[WIDTH-1:1], w_g0[0] | w_p0[0]};

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int D = 1 << k;
      logic [WIDTH-1:0] w_g_in;
      logic [WIDTH-1:0] w_p_in;
      logic [WIDTH-1:0] w_g_out;
      logic [WIDTH-1:0] w_p_out;

      if (k == 0) begin : g_src
         assign w_g_in = w_g0_cin;
         assign w_p_in = w_p0;
      end else if (k == S1_LVL) begin : g_src
         assign w_g_in = r_s1_g;
         assign w_p_in = r_s1_pp;
      end else begin : g_src
         assign w_g_in = g_lvl[k-1].w_g_out;
         assign w_p_in = g_lvl[k-1].w_p_out;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_cell
            gp_t w_hi;
            gp_t w_lo;
            gp_t w_out;
            assign w_hi = '{g: w_g_in[i],   p: w_p_in[i]};
            assign w_lo = '{g: w_g_in[i-D], p: w_p_in[i-D]};
            prefix_gp_cell u_cell (
               .i_hi (w_hi),
               .i_lo (w_lo),
               .o_gp (w_out)
            );
            assign w_g_out[i] = w_out.g;
            assign w_p_out[i] = w_out.p;
         end else begin : g_pass
            assign w_g_out[i] = w_g_in[i];
            assign w_p_out[i] = w_p_in[i];
         end
      end
   end

   // Group propagate after the last level has no consumer; carries need G only.
   assign w_unused_p = ^g_lvl[LEVELS-1].w_p_out;

   assign w_c    = g_lvl[LEVELS-1].w_g_out;
   assign w_diff = r_s1_p ^ {w_c[WIDTH-2:0], 1'b1};

`ifdef PREFIXSUB_OVF_EN
   logic r_s1_amsb;
   logic r_ovf;
   logic w_ovf;
   // ~p[MSB] is a[MSB] ^ b[MSB] since p = a ^ ~b.
   assign w_ovf = ~r_s1_p[WIDTH-1] & (r_s1_amsb ^ w_diff[WIDTH-1]);
   assign ovf   = r_ovf;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_g     <= '0;
         r_s1_pp    <= '0;
         r_s1_p     <= '0;
         r_diff     <= '0;
         r_borrow   <= 1'b0;
`ifdef PREFIXSUB_OVF_EN
         r_s1_amsb  <= 1'b0;
         r_ovf      <= 1'b0;
`endif
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            r_s1_g  <= g_lvl[S1_LVL-1].w_g_out;
            r_s1_pp <= g_lvl[S1_LVL-1].w_p_out;
            r_s1_p  <= w_p0;
`ifdef PREFIXSUB_OVF_EN
            r_s1_amsb <= a[WIDTH-1];
`endif
         end
         if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv && r_s1_valid) begin
            r_diff   <= w_diff;
            r_borrow <= ~w_c[WIDTH-1];
`ifdef PREFIXSUB_OVF_EN
            r_ovf    <= w_ovf;
`endif
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign diff      = r_diff;
   assign borrow    = r_borrow;

endmodule
